id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter XLEN, default 64, datapath width.
REQ-002 SHALL have ports:
- clk  input  1  rising-edge clock
- resetN  input  1  reset, asynchronous, active-low
- readData1, readData2  input  XLEN  register-file read data
- readReg1, readReg2  input  5  source register addresses presented to the register file
- rdIn  input  5  destination register
- immIn, pcIn  input  XLEN  immediate, PC
- ctrlIn  input  8  {regWrite, memRead, memWrite, memToReg, aluSrc, branch, aluOp[1:0]}, bit 7 = regWrite
- validIn  input  1  decode slot holds a real instruction
- wbWriteReg  input  5  write-back destination
- wbWriteData  input  XLEN  write-back data
- wbRegWrite  input  1  write-back enable
- flush  input  1  kill the instruction entering EX
- stallExt  input  1  downstream stall, hold stage
- readData1Out, readData2Out, immOut, pcOut  output  XLEN  registered operands
- rs1Out, rs2Out, rdOut  output  5  registered addresses
- ctrlOut  output  8  registered control
- validOut  output  1  EX slot valid
- stallOut  output  1  combinational load-use stall to IF/ID
- stallCount  output  16  load-use bubble counter

Function
REQ-003 SHALL define hazard = validOut & ctrlOut[6] (memRead) & (rdOut != 0) & validIn & ((rdOut == readReg1) | (rdOut == readReg2)).
REQ-004 SHALL drive stallOut = hazard & ~flush & ~stallExt, combinationally.
REQ-005 SHALL, on each rising edge, apply exactly one action, highest priority first: FLUSH (flush=1), HOLD (stallExt=1), BUBBLE (hazard=1), LOAD (otherwise).
REQ-006 FLUSH: validOut<=0 and ctrlOut<=0; all other outputs hold.
REQ-007 HOLD: every register holds its value, including validOut and ctrlOut.
REQ-008 BUBBLE: validOut<=0 and ctrlOut<=0; other outputs hold; stallCount increments.
REQ-009 LOAD: every output register captures its input; validOut<=validIn; ctrlOut<=validIn ? ctrlIn : 0.
REQ-010 SHALL, on LOAD, capture operand n as follows:
- 0 if readRegn == 0;
- else wbWriteData if wbRegWrite & (wbWriteReg == readRegn) & (wbWriteReg != 0);
- else readDatan.
REQ-011 SHALL apply the REQ-010 bypass independently per operand; both operands may bypass in the same cycle.
REQ-012 stallCount SHALL saturate at 16'hFFFF; it SHALL NOT wrap.
REQ-013 A BUBBLE SHALL last exactly one cycle: the following edge sees validOut=0, so hazard=0 and the held decode instruction LOADs.
REQ-014 With rdOut == readReg1 == readReg2, REQ-003 SHALL raise a single hazard and insert one bubble.
REQ-015 Latency SHALL be one cycle, decode inputs to EX outputs.
REQ-016 SHALL contain no combinational path from any input to a registered output.

Reset
REQ-017 SHALL, while resetN=0, asynchronously clear all output registers to 0, including validOut, ctrlOut and stallCount.
REQ-018 SHALL clear state immediately on resetN assertion mid-operation, including during a HOLD or on the BUBBLE edge.
REQ-019 SHALL resume normal operation on the first rising edge after resetN deasserts.
REQ-020 With outputs cleared, stallOut SHALL be 0 during and after reset.

Verification
REQ-021 Basic LOAD: readReg1=3, readData1=0x11, readReg2=4, readData2=0x22, validIn=1, ctrlIn=0x80, no WB write. Required after one edge: readData1Out=0x11, readData2Out=0x22, ctrlOut=0x80, validOut=1.
REQ-022 Load-use: EX holds a load (ctrlOut=0xC0, rdOut=5, validOut=1); decode readReg2=5. Required: stallOut=1; next edge gives validOut=0, stallCount=1; following edge loads the decode instruction.
REQ-023 WB bypass and x0:
- wbRegWrite=1, wbWriteReg=7, wbWriteData=0xABCD, readReg1=7, readData1=0x0 -> readData1Out=0xABCD.
- readReg2=0, readData2=0x55 -> readData2Out=0.
- Same case with wbWriteReg=0 -> no bypass.
REQ-024 Priority, run as two separate cases:
- flush=1 and stallExt=1 together with a hazard -> validOut=0, stallCount unchanged.
- stallExt=1 alone -> all outputs unchanged, stallOut=0.
REQ-025 Reset: assert resetN=0 asynchronously between edges while validOut=1 and stallCount=3. Required: all outputs read 0 before the next edge.
REQ-026 Saturation: preload stallCount to 0xFFFF, then force a hazard. Required: stallCount stays 0xFFFF.

Source files
------------

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// id_ex_stage : ID/EX pipeline register with load-use hazard detection,
//               write-back bypass and a saturating load-use bubble counter.
// Revision    : 1.0
// ============================================================================
module id_ex_stage #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            resetN,
  input  logic [XLEN-1:0] readData1,
  input  logic [XLEN-1:0] readData2,
  input  logic [4:0]      readReg1,
  input  logic [4:0]      readReg2,
  input  logic [4:0]      rdIn,
  input  logic [XLEN-1:0] immIn,
  input  logic [XLEN-1:0] pcIn,
  input  logic [7:0]      ctrlIn,
  input  logic            validIn,
  input  logic [4:0]      wbWriteReg,
  input  logic [XLEN-1:0] wbWriteData,
  input  logic            wbRegWrite,
  input  logic            flush,
  input  logic            stallExt,
  output logic [XLEN-1:0] readData1Out,
  output logic [XLEN-1:0] readData2Out,
  output logic [XLEN-1:0] immOut,
  output logic [XLEN-1:0] pcOut,
  output logic [4:0]      rs1Out,
  output logic [4:0]      rs2Out,
  output logic [4:0]      rdOut,
  output logic [7:0]      ctrlOut,
  output logic            validOut,
  output logic            stallOut,
  output logic [15:0]     stallCount
);

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  logic [XLEN-1:0] read_data1_q, read_data1_d;
  logic [XLEN-1:0] read_data2_q, read_data2_d;
  logic [XLEN-1:0] imm_q, imm_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [4:0]      rs1_q, rs1_d;
  logic [4:0]      rs2_q, rs2_d;
  logic [4:0]      rd_q, rd_d;
  logic [7:0]      ctrl_q, ctrl_d;
  logic            valid_q, valid_d;
  logic [15:0]     stall_count_q, stall_count_d;
  logic            hazard;

  // x0 always reads zero; otherwise a same-cycle write-back wins over the stale file value.
  function automatic logic [XLEN-1:0] bypass(
    input logic [4:0]      rs,
    input logic [XLEN-1:0] rf_data,
    input logic            wb_en,
    input logic [4:0]      wb_reg,
    input logic [XLEN-1:0] wb_data
  );
    logic [XLEN-1:0] result;
    result = rf_data;
    if (rs == 5'd0) begin
      result = '0;
    end else if (wb_en && (wb_reg == rs) && (wb_reg != 5'd0)) begin
      result = wb_data;
    end
    return result;
  endfunction

  assign hazard = valid_q && ctrl_q[6] && (rd_q != 5'd0) && validIn &&
                  ((rd_q == readReg1) || (rd_q == readReg2));

  assign stallOut = hazard && !flush && !stallExt;

  always_comb begin
    read_data1_d  = read_data1_q;
    read_data2_d  = read_data2_q;
    imm_d         = imm_q;
    pc_d          = pc_q;
    rs1_d         = rs1_q;
    rs2_d         = rs2_q;
    rd_d          = rd_q;
    ctrl_d        = ctrl_q;
    valid_d       = valid_q;
    stall_count_d = stall_count_q;
    if (flush) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end else if (stallExt) begin
      // hold: defaults already keep every register
    end else if (hazard) begin
      // The bubble clears validOut, so the next edge cannot re-detect this hazard.
      valid_d = 1'b0;
      ctrl_d  = '0;
      if (stall_count_q != CNT_MAX) begin
        stall_count_d = stall_count_q + 16'd1;
      end
    end else begin
      read_data1_d = bypass(readReg1, readData1, wbRegWrite, wbWriteReg, wbWriteData);
      read_data2_d = bypass(readReg2, readData2, wbRegWrite, wbWriteReg, wbWriteData);
      imm_d        = immIn;
      pc_d         = pcIn;
      rs1_d        = readReg1;
      rs2_d        = readReg2;
      rd_d         = rdIn;
      valid_d      = validIn;
      ctrl_d       = validIn ? ctrlIn : 8'd0;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      read_data1_q  <= '0;
      read_data2_q  <= '0;
      imm_q         <= '0;
      pc_q          <= '0;
      rs1_q         <= '0;
      rs2_q         <= '0;
      rd_q          <= '0;
      ctrl_q        <= '0;
      valid_q       <= 1'b0;
      stall_count_q <= '0;
    end else begin
      read_data1_q  <= read_data1_d;
      read_data2_q  <= read_data2_d;
      imm_q         <= imm_d;
      pc_q          <= pc_d;
      rs1_q         <= rs1_d;
      rs2_q         <= rs2_d;
      rd_q          <= rd_d;
      ctrl_q        <= ctrl_d;
      valid_q       <= valid_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign readData1Out = read_data1_q;
  assign readData2Out = read_data2_q;
  assign immOut       = imm_q;
  assign pcOut        = pc_q;
  assign rs1Out       = rs1_q;
  assign rs2Out       = rs2_q;
  assign rdOut        = rd_q;
  assign ctrlOut      = ctrl_q;
  assign validOut     = valid_q;
  assign stallCount   = stall_count_q;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
// tb_id_ex_stage : scoreboard bench for the ID/EX pipeline register.
// Revision       : 1.0
// ============================================================================
module tb_id_ex_stage;

  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            resetN;
  logic [XLEN-1:0] readData1, readData2, immIn, pcIn, wbWriteData;
  logic [4:0]      readReg1, readReg2, rdIn, wbWriteReg;
  logic [7:0]      ctrlIn;
  logic            validIn, wbRegWrite, flush, stallExt;
  logic [XLEN-1:0] readData1Out, readData2Out, immOut, pcOut;
  logic [4:0]      rs1Out, rs2Out, rdOut;
  logic [7:0]      ctrlOut;
  logic            validOut, stallOut;
  logic [15:0]     stallCount;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic [XLEN-1:0] rd1, rd2, imm, pc;
    logic [4:0]      rs1, rs2, rd;
    logic [7:0]      ctrl;
    logic            valid;
    logic [15:0]     cnt;
  } exp_t;

  exp_t sb_q[$];

  // reference model state
  logic [XLEN-1:0] m_rd1, m_rd2, m_imm, m_pc;
  logic [4:0]      m_rs1, m_rs2, m_rd;
  logic [7:0]      m_ctrl;
  logic            m_valid;
  logic [15:0]     m_cnt;

  id_ex_stage #(.XLEN(XLEN)) dut (
    .clk(clk), .resetN(resetN),
    .readData1(readData1), .readData2(readData2),
    .readReg1(readReg1), .readReg2(readReg2), .rdIn(rdIn),
    .immIn(immIn), .pcIn(pcIn), .ctrlIn(ctrlIn), .validIn(validIn),
    .wbWriteReg(wbWriteReg), .wbWriteData(wbWriteData), .wbRegWrite(wbRegWrite),
    .flush(flush), .stallExt(stallExt),
    .readData1Out(readData1Out), .readData2Out(readData2Out),
    .immOut(immOut), .pcOut(pcOut),
    .rs1Out(rs1Out), .rs2Out(rs2Out), .rdOut(rdOut),
    .ctrlOut(ctrlOut), .validOut(validOut),
    .stallOut(stallOut), .stallCount(stallCount)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [XLEN-1:0] model_fwd(input logic [4:0] rs, input logic [XLEN-1:0] rf);
    if (rs == 5'd0) return '0;
    if (wbRegWrite && wbWriteReg == rs && wbWriteReg != 5'd0) return wbWriteData;
    return rf;
  endfunction

  task automatic model_reset();
    m_rd1 = '0; m_rd2 = '0; m_imm = '0; m_pc = '0;
    m_rs1 = '0; m_rs2 = '0; m_rd = '0; m_ctrl = '0; m_valid = 1'b0; m_cnt = '0;
  endtask

  task automatic idle_inputs();
    readData1 = '0; readData2 = '0; immIn = '0; pcIn = '0; wbWriteData = '0;
    readReg1 = '0; readReg2 = '0; rdIn = '0; wbWriteReg = '0; ctrlIn = '0;
    validIn = 1'b0; wbRegWrite = 1'b0; flush = 1'b0; stallExt = 1'b0;
  endtask

  // Called at a falling edge with inputs already driven; returns at the next falling edge.
  task automatic step(input string tag);
    exp_t e;
    logic hz;
    #1;
    hz = m_valid && m_ctrl[6] && (m_rd != 5'd0) && validIn &&
         ((m_rd == readReg1) || (m_rd == readReg2));
    check({tag, ".stallOut"}, 64'(stallOut), 64'(hz && !flush && !stallExt));
    if (flush) begin
      m_valid = 1'b0; m_ctrl = '0;
    end else if (stallExt) begin
      m_valid = m_valid;
    end else if (hz) begin
      m_valid = 1'b0; m_ctrl = '0;
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end else begin
      m_rd1 = model_fwd(readReg1, readData1);
      m_rd2 = model_fwd(readReg2, readData2);
      m_imm = immIn; m_pc = pcIn;
      m_rs1 = readReg1; m_rs2 = readReg2; m_rd = rdIn;
      m_valid = validIn; m_ctrl = validIn ? ctrlIn : 8'd0;
    end
    e.rd1 = m_rd1; e.rd2 = m_rd2; e.imm = m_imm; e.pc = m_pc;
    e.rs1 = m_rs1; e.rs2 = m_rs2; e.rd = m_rd;
    e.ctrl = m_ctrl; e.valid = m_valid; e.cnt = m_cnt;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check({tag, ".rd1"},   readData1Out, e.rd1);
    check({tag, ".rd2"},   readData2Out, e.rd2);
    check({tag, ".imm"},   immOut, e.imm);
    check({tag, ".pc"},    pcOut, e.pc);
    check({tag, ".rs"},    {54'd0, rs1Out, rs2Out}, {54'd0, e.rs1, e.rs2});
    check({tag, ".rd"},    64'(rdOut), 64'(e.rd));
    check({tag, ".ctrl"},  64'(ctrlOut), 64'(e.ctrl));
    check({tag, ".valid"}, 64'(validOut), 64'(e.valid));
    check({tag, ".cnt"},   64'(stallCount), 64'(e.cnt));
    @(negedge clk);
  endtask

  // Puts a load writing x5 into EX, then presents a consumer of x5 in decode.
  task automatic setup_load_use(input string tag);
    validIn = 1'b1; ctrlIn = 8'hC0; rdIn = 5'd5;
    readReg1 = 5'd1; readReg2 = 5'd2; readData1 = 64'h1; readData2 = 64'h2;
    immIn = 64'h40; pcIn = 64'h100;
    step({tag, ".load"});
    readReg1 = 5'd6; readReg2 = 5'd5; readData1 = 64'h66; readData2 = 64'h55;
    ctrlIn = 8'h80; rdIn = 5'd8; immIn = 64'h8; pcIn = 64'h104;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] saved_cnt;
    idle_inputs();
    model_reset();
    resetN = 1'b0;
    repeat (2) @(negedge clk);
    check("rst.valid", 64'(validOut), 64'd0);
    check("rst.cnt", 64'(stallCount), 64'd0);
    check("rst.stallOut", 64'(stallOut), 64'd0);
    resetN = 1'b1;

    // basic load
    readReg1 = 5'd3; readData1 = 64'h11; readReg2 = 5'd4; readData2 = 64'h22;
    validIn = 1'b1; ctrlIn = 8'h80; rdIn = 5'd9; immIn = 64'h7; pcIn = 64'h200;
    step("basic");
    check("basic.rd1k", readData1Out, 64'h11);
    check("basic.rd2k", readData2Out, 64'h22);
    check("basic.ctrlk", 64'(ctrlOut), 64'h80);
    check("basic.validk", 64'(validOut), 64'd1);

    // three load-use bubbles
    for (int i = 0; i < 3; i++) begin
      setup_load_use("lu");
      #1 check("lu.stallOutk", 64'(stallOut), 64'd1);
      step("lu.bubble");
      check("lu.bubble.validk", 64'(validOut), 64'd0);
      check("lu.bubble.cntk", 64'(stallCount), 64'(i + 1));
      step("lu.reload");
      check("lu.reload.rdk", 64'(rdOut), 64'd8);
      check("lu.reload.validk", 64'(validOut), 64'd1);
    end

    // asynchronous reset between edges while validOut=1 and stallCount=3
    #2 resetN = 1'b0;
    #1;
    check("arst.any", {readData1Out | readData2Out | immOut | pcOut},  64'd0);
    check("arst.addr", {49'd0, rs1Out, rs2Out, rdOut}, 64'd0);
    check("arst.ctl", {39'd0, ctrlOut, validOut, stallCount}, 64'd0);
    check("arst.stallOut", 64'(stallOut), 64'd0);
    @(negedge clk);
    resetN = 1'b1;
    model_reset();

    // single hazard when both sources match the load destination
    setup_load_use("dual");
    readReg1 = 5'd5;
    step("dual.bubble");
    check("dual.cntk", 64'(stallCount), 64'd1);
    step("dual.reload");

    // write-back bypass and x0
    wbRegWrite = 1'b1; wbWriteReg = 5'd7; wbWriteData = 64'hABCD;
    readReg1 = 5'd7; readData1 = 64'h0; readReg2 = 5'd0; readData2 = 64'h55;
    step("wb");
    check("wb.rd1k", readData1Out, 64'hABCD);
    check("wb.rd2k", readData2Out, 64'h0);
    wbWriteReg = 5'd0; readData1 = 64'h1234; readReg2 = 5'd0;
    step("wb0");
    check("wb0.rd1k", readData1Out, 64'h1234);
    wbWriteReg = 5'd9; readReg1 = 5'd9; readReg2 = 5'd9; readData2 = 64'h77;
    step("wbboth");
    check("wbboth.rd2k", readData2Out, 64'hABCD);
    wbRegWrite = 1'b0;
    step("wboff");
    check("wboff.rd1k", readData1Out, 64'h1234);

    // flush + stallExt together with a hazard
    setup_load_use("prio1");
    saved_cnt = stallCount;
    flush = 1'b1; stallExt = 1'b1;
    step("prio1.flush");
    check("prio1.validk", 64'(validOut), 64'd0);
    check("prio1.cntk", 64'(stallCount), 64'(saved_cnt));
    flush = 1'b0; stallExt = 1'b0;
    step("prio1.after");

    // stallExt alone with a hazard
    setup_load_use("prio2");
    stallExt = 1'b1;
    step("prio2.hold");
    check("prio2.ctrlk", 64'(ctrlOut), 64'hC0);
    check("prio2.validk", 64'(validOut), 64'd1);
    stallExt = 1'b0;
    step("prio2.bubble");
    step("prio2.reload");

    // random traffic
    for (int i = 0; i < 60; i++) begin
      readData1 = {$urandom, $urandom}; readData2 = {$urandom, $urandom};
      immIn = {$urandom, $urandom}; pcIn = {$urandom, $urandom};
      wbWriteData = {$urandom, $urandom};
      readReg1 = 5'($urandom_range(0, 7)); readReg2 = 5'($urandom_range(0, 7));
      rdIn = 5'($urandom_range(0, 7)); wbWriteReg = 5'($urandom_range(0, 7));
      ctrlIn = 8'($urandom); validIn = ($urandom_range(0, 3) != 0);
      wbRegWrite = 1'($urandom); flush = ($urandom_range(0, 7) == 0);
      stallExt = ($urandom_range(0, 7) == 0);
      step("rand");
    end
    idle_inputs();

    // saturation: preload the counter one below the limit via a flush edge
    flush = 1'b1;
    force dut.stall_count_d = 16'hFFFE;
    @(posedge clk);
    #1;
    release dut.stall_count_d;
    m_valid = 1'b0; m_ctrl = '0; m_cnt = 16'hFFFE;
    check("sat.preload", 64'(stallCount), 64'hFFFE);
    @(negedge clk);
    flush = 1'b0;
    for (int i = 0; i < 2; i++) begin
      setup_load_use("sat");
      step("sat.bubble");
      check("sat.cntk", 64'(stallCount), 64'hFFFF);
      step("sat.reload");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
